// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Control sequencer for a small accumulator CPU. Every
//               instruction runs FETCH -> DECODE -> OPRD -> EXEC; HLT parks
//               the machine in HALT until reset. The ALU and memory are
//               external to this block.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               mem_rdata           - memory read data (one cycle after mem_rd)
//               alu_out, a_is_zero  - ALU result and accumulator-zero flag
//               opcode, acc         - instruction opcode and accumulator to ALU
//               mem_addr, mem_rd,
//               mem_wr, mem_wdata   - memory access port
//               pc, halt            - program counter and halted status
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              a_is_zero,
    output logic [2:0]        opcode,
    output logic [WIDTH-1:0]  acc,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [AWIDTH-1:0] pc,
    output logic              halt
);

    // State encoding
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_OPRD   = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_HALT   = 3'd4;

    // Opcode encoding
    localparam logic [2:0] c_OP_HLT = 3'd0;
    localparam logic [2:0] c_OP_SKZ = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_LDA = 3'd5;
    localparam logic [2:0] c_OP_STO = 3'd6;
    localparam logic [2:0] c_OP_JMP = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [AWIDTH-1:0] r_pc;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_ir;
    logic              r_halt;

    logic [2:0]        w_op;
    logic [AWIDTH-1:0] w_ir_addr;
    logic [AWIDTH-1:0] w_pc_inc;
    logic              w_uses_operand;
    logic              w_rd;
    logic              w_wr;
    logic [AWIDTH-1:0] w_addr;

    assign w_op      = r_ir[WIDTH-1 -: 3];
    assign w_ir_addr = r_ir[AWIDTH-1:0];
    // Natural AWIDTH-bit overflow gives the silent wrap to address 0.
    assign w_pc_inc  = r_pc + AWIDTH'(1);

    // Instructions whose operand comes from memory through the ALU.
    assign w_uses_operand = (w_op == c_OP_ADD) || (w_op == c_OP_AND) ||
                            (w_op == c_OP_XOR) || (w_op == c_OP_LDA);

    // Next state and memory strobes
    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_addr       = r_pc;
        case (r_state)
            c_ST_FETCH: begin
                w_rd         = 1'b1;
                w_state_next = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                w_state_next = c_ST_OPRD;
            end
            c_ST_OPRD: begin
                w_addr       = w_ir_addr;
                w_rd         = w_uses_operand;
                w_state_next = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                if (w_op == c_OP_STO) begin
                    w_wr   = 1'b1;
                    w_addr = w_ir_addr;
                end
                w_state_next = (w_op == c_OP_HLT) ? c_ST_HALT : c_ST_FETCH;
            end
            c_ST_HALT: begin
                w_state_next = c_ST_HALT;
            end
            default: begin
                w_state_next = c_ST_FETCH;
            end
        endcase
    end

    // Strobes are squashed combinationally by rst so an in-flight STO
    // cannot write during the reset cycle.
    assign mem_rd    = w_rd & ~rst;
    assign mem_wr    = w_wr & ~rst;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_acc;
    assign opcode    = w_op;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign halt      = r_halt;

    // State, program counter, accumulator and instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
            r_pc    <= '0;
            r_acc   <= '0;
            r_ir    <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_halt  <= (w_state_next == c_ST_HALT);
            if (r_state == c_ST_DECODE) begin
                r_ir <= mem_rdata;
                r_pc <= w_pc_inc;
            end
            if (r_state == c_ST_EXEC) begin
                case (w_op)
                    c_OP_ADD, c_OP_AND, c_OP_XOR, c_OP_LDA: r_acc <= alu_out;
                    c_OP_JMP: r_pc <= w_ir_addr;
                    c_OP_SKZ: begin
                        if (a_is_zero) begin
                            r_pc <= w_pc_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer with a behavioural
//               memory and ALU; expected writes and accumulator updates are
//               queued when a program is loaded and popped as the DUT
//               produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int WIDTH  = 8;
    localparam int AWIDTH = 5;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [WIDTH-1:0]  data;
        int                cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  mem_rdata = '0;
    logic [WIDTH-1:0]  alu_out;
    logic              a_is_zero;
    logic [2:0]        opcode;
    logic [WIDTH-1:0]  acc;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [AWIDTH-1:0] pc;
    logic              halt;

    logic [WIDTH-1:0]  mem [32];
    logic [31:0]       rd_seen;
    logic [WIDTH-1:0]  prev_acc;
    int                cyc;
    int                checks = 0;
    int                errors = 0;
    ev_t               wr_q[$];
    ev_t               acc_q[$];

    cpu_sequencer #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .alu_out   (alu_out),
        .a_is_zero (a_is_zero),
        .opcode    (opcode),
        .acc       (acc),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .pc        (pc),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    // Program memory (read-only here; writes are checked, not stored)
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Reference ALU
    always_comb begin
        alu_out = acc;
        case (opcode)
            3'd2:    alu_out = acc + mem_rdata;
            3'd3:    alu_out = acc & mem_rdata;
            3'd4:    alu_out = acc ^ mem_rdata;
            3'd5:    alu_out = mem_rdata;
            default: alu_out = acc;
        endcase
    end
    assign a_is_zero = (acc == '0);

    // Cycle 0 is the first fetch after reset is released.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        ev_t e;
        check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
        check("wdata_eq_acc", {24'd0, mem_wdata}, {24'd0, acc});
        if (rst) check("rst_no_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
        if (mem_wr) begin
            check("wr_expected", {31'd0, wr_q.size() != 0}, 32'd1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("wr_addr", {27'd0, mem_addr}, {27'd0, e.addr});
                check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (!rst && (acc !== prev_acc)) begin
            check("acc_expected", {31'd0, acc_q.size() != 0}, 32'd1);
            if (acc_q.size() != 0) begin
                e = acc_q.pop_front();
                check("acc_value", {24'd0, acc}, {24'd0, e.data});
                check("acc_cycle", cyc, e.cyc);
            end
        end
        prev_acc <= acc;
        if (rst)         rd_seen <= '0;
        else if (mem_rd) rd_seen[mem_addr] <= 1'b1;
    end

    task automatic load(input logic [WIDTH-1:0] img [32]);
        for (int i = 0; i < 32; i++) mem[i] = img[i];
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pc", {27'd0, pc}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (halt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", {31'd0, halt}, 32'd1);
    endtask

    task automatic drain(input string tag);
        check({tag, "_wr_q_empty"}, wr_q.size(), 32'd0);
        check({tag, "_acc_q_empty"}, acc_q.size(), 32'd0);
        wr_q.delete();
        acc_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] img [32];

        // LDA 16; ADD 17; STO 18; HLT
        for (int i = 0; i < 32; i++) img[i] = '0;
        img[0] = 8'hB0; img[1] = 8'h51; img[2] = 8'hD2; img[3] = 8'h00;
        img[16] = 8'h05; img[17] = 8'h03;
        load(img);
        acc_q.push_back('{addr: 5'd0, data: 8'h05, cyc: 4});
        acc_q.push_back('{addr: 5'd0, data: 8'h08, cyc: 8});
        wr_q.push_back('{addr: 5'h12, data: 8'h08, cyc: 11});
        do_reset();
        @(negedge clk);
        check("p1_first_fetch_rd", {31'd0, mem_rd}, 32'd1);
        check("p1_first_fetch_addr", {27'd0, mem_addr}, 32'd0);
        repeat (15) @(negedge clk);
        check("p1_no_halt_c15", {31'd0, halt}, 32'd0);
        @(negedge clk);
        check("p1_halt_c16", {31'd0, halt}, 32'd1);
        check("p1_pc", {27'd0, pc}, 32'd4);
        check("p1_acc", {24'd0, acc}, 32'h08);
        repeat (3) @(negedge clk);
        check("p1_halt_holds", {31'd0, halt}, 32'd1);
        check("p1_halt_no_rd", {31'd0, mem_rd}, 32'd0);
        drain("p1");

        // SKZ with acc=0 skips address 1; JMP 5; HLT
        for (int i = 0; i < 32; i++) img[i] = '0;
        img[0] = 8'h20; img[1] = 8'hB0; img[2] = 8'hE5; img[5] = 8'h00;
        load(img);
        do_reset();
        wait_halt(60);
        check("p2_pc", {27'd0, pc}, 32'd6);
        check("p2_addr1_unread", {31'd0, rd_seen[1]}, 32'd0);
        check("p2_addr5_read", {31'd0, rd_seen[5]}, 32'd1);
        drain("p2");

        // LDA 16 (=1); SKZ must not skip; HLT at 2
        for (int i = 0; i < 32; i++) img[i] = '0;
        img[0] = 8'hB0; img[1] = 8'h20; img[2] = 8'h00; img[16] = 8'h01;
        load(img);
        acc_q.push_back('{addr: 5'd0, data: 8'h01, cyc: 4});
        do_reset();
        wait_halt(60);
        check("p3_pc", {27'd0, pc}, 32'd3);
        check("p3_acc", {24'd0, acc}, 32'h01);
        check("p3_addr2_read", {31'd0, rd_seen[2]}, 32'd1);
        drain("p3");

        // JMP 31; HLT at 31 -> pc wraps
        for (int i = 0; i < 32; i++) img[i] = '0;
        img[0] = 8'hFF; img[31] = 8'h00;
        load(img);
        do_reset();
        wait_halt(60);
        check("p4_pc_wrap", {27'd0, pc}, 32'd0);
        check("p4_addr31_read", {31'd0, rd_seen[31]}, 32'd1);
        drain("p4");

        // LDA 16; AND 17; XOR 17; HLT
        for (int i = 0; i < 32; i++) img[i] = '0;
        img[0] = 8'hB0; img[1] = 8'h71; img[2] = 8'h91; img[3] = 8'h00;
        img[16] = 8'hF0; img[17] = 8'h3C;
        load(img);
        acc_q.push_back('{addr: 5'd0, data: 8'hF0, cyc: 4});
        acc_q.push_back('{addr: 5'd0, data: 8'h30, cyc: 8});
        acc_q.push_back('{addr: 5'd0, data: 8'h0C, cyc: 12});
        do_reset();
        wait_halt(60);
        check("p5_acc", {24'd0, acc}, 32'h0C);
        check("p5_pc", {27'd0, pc}, 32'd4);
        drain("p5");

        // LDA 16; STO 18 interrupted by reset in EXEC; rerun to completion
        for (int i = 0; i < 32; i++) img[i] = '0;
        img[0] = 8'hB0; img[1] = 8'hD2; img[2] = 8'h00; img[16] = 8'h5A;
        load(img);
        acc_q.push_back('{addr: 5'd0, data: 8'h5A, cyc: 4});
        do_reset();
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        acc_q.push_back('{addr: 5'd0, data: 8'h00, cyc: 0});
        #1;
        check("p6_sto_rst_wr", {31'd0, mem_wr}, 32'd0);
        check("p6_sto_rst_rd", {31'd0, mem_rd}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        acc_q.push_back('{addr: 5'd0, data: 8'h5A, cyc: 4});
        wr_q.push_back('{addr: 5'h12, data: 8'h5A, cyc: 7});
        #1;
        check("p6_after_rst_rd", {31'd0, mem_rd}, 32'd1);
        check("p6_after_rst_addr", {27'd0, mem_addr}, 32'd0);
        check("p6_after_rst_pc", {27'd0, pc}, 32'd0);
        check("p6_after_rst_acc", {24'd0, acc}, 32'd0);
        wait_halt(60);
        check("p6_pc", {27'd0, pc}, 32'd3);
        drain("p6");

        // Reset out of HALT
        do_reset();
        #1;
        check("halt_rst_clear", {31'd0, halt}, 32'd0);
        check("halt_rst_fetch", {31'd0, mem_rd}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
